key_cmd_gen: RTL and testbench

KEY_CMD_GEN -- requirements
Module: key_cmd_gen

---
 rtl/key_cmd_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_key_cmd_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_gen.sv
// key_cmd_gen: turns debounced key levels into single-cycle move strobes for
// the game core and generates the gravity (force_down) strobe.
//   - left/right: delayed auto-shift (first pulse, DAS_DELAY wait, then repeat
//     every DAS_RATE cycles); both keys held cancels both.
//   - down: soft drop, pulse on press then every DAS_RATE cycles.
//   - rotate_hold: one pulse per key_rotate rising edge.
//   - force_down: gravity tick with a level-dependent period.
// Build option: define GRAVITY_LEVEL_EN to enable score-driven speed levels.
// Without it, level stays 0 and the gravity period is fixed at GRAV_BASE.
module key_cmd_gen #(
    parameter int         DAS_DELAY = 16,
    parameter int         DAS_RATE  = 4,
    parameter int         GRAV_BASE = 64,
    parameter int         GRAV_STEP = 4,
    parameter int         GRAV_MIN  = 8,
    parameter int         LEVEL_PTS = 10,
    parameter logic [4:0] PLAY_CODE = 5'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_down,
    input  logic        key_rotate,
    input  logic [4:0]  state,
    input  logic [31:0] score,
    output logic        left,
    output logic        right,
    output logic        down,
    output logic        rotate_hold,
    output logic        force_down,
    output logic [3:0]  level
);

    // Counter reload values; a zero or negative parameter behaves like 1 so
    // the counters never underflow.
    localparam logic [31:0] DELAY_LOAD  = (DAS_DELAY < 1) ? 32'd1 : 32'(DAS_DELAY);
    localparam logic [31:0] RATE_LOAD   = (DAS_RATE  < 1) ? 32'd1 : 32'(DAS_RATE);
    localparam logic [31:0] BASE_PERIOD = (GRAV_BASE < 1) ? 32'd1 : 32'(GRAV_BASE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } das_state_t;

    logic        in_play;
    logic        lr_conflict;
    logic [1:0]  lr_key;

    // Index 0 is the left channel, index 1 the right channel.
    das_state_t  das_state [2];
    logic [31:0] das_cnt   [2];
    logic [1:0]  das_pulse;

    logic        dn_active;
    logic [31:0] dn_cnt;

    logic        rot_q;

    logic [31:0] grav_cnt;
    logic [31:0] grav_period;
    logic [31:0] next_period;

    assign in_play     = (state == PLAY_CODE);
    assign lr_conflict = key_left & key_right;
    assign lr_key      = {key_right, key_left};

    assign left  = das_pulse[0];
    assign right = das_pulse[1];

    // Left/right auto-shift FSMs. A key that is not effectively pressed (released,
    // cancelled by the opposite key, or outside play) parks its FSM in IDLE, so
    // the surviving key of a simultaneous press restarts as a fresh press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                das_state[i] <= S_IDLE;
                das_cnt[i]   <= 32'd0;
            end
            das_pulse <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!in_play || !lr_key[i] || lr_conflict) begin
                    das_state[i] <= S_IDLE;
                    das_cnt[i]   <= 32'd0;
                    das_pulse[i] <= 1'b0;
                end else begin
                    case (das_state[i])
                        S_IDLE: begin
                            das_state[i] <= S_DELAY;
                            das_cnt[i]   <= DELAY_LOAD;
                            das_pulse[i] <= 1'b1;
                        end
                        S_DELAY: begin
                            if (das_cnt[i] <= 32'd1) begin
                                das_state[i] <= S_REPEAT;
                                das_cnt[i]   <= RATE_LOAD;
                                das_pulse[i] <= 1'b1;
                            end else begin
                                das_cnt[i]   <= das_cnt[i] - 32'd1;
                                das_pulse[i] <= 1'b0;
                            end
                        end
                        S_REPEAT: begin
                            if (das_cnt[i] <= 32'd1) begin
                                das_cnt[i]   <= RATE_LOAD;
                                das_pulse[i] <= 1'b1;
                            end else begin
                                das_cnt[i]   <= das_cnt[i] - 32'd1;
                                das_pulse[i] <= 1'b0;
                            end
                        end
                        default: begin
                            das_state[i] <= S_IDLE;
                            das_cnt[i]   <= 32'd0;
                            das_pulse[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Soft drop: pulse on the press, then every DAS_RATE cycles while held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dn_active <= 1'b0;
            dn_cnt    <= 32'd0;
            down      <= 1'b0;
        end else if (!in_play || !key_down) begin
            dn_active <= 1'b0;
            dn_cnt    <= 32'd0;
            down      <= 1'b0;
        end else if (!dn_active) begin
            dn_active <= 1'b1;
            dn_cnt    <= RATE_LOAD;
            down      <= 1'b1;
        end else if (dn_cnt <= 32'd1) begin
            dn_cnt    <= RATE_LOAD;
            down      <= 1'b1;
        end else begin
            dn_cnt    <= dn_cnt - 32'd1;
            down      <= 1'b0;
        end
    end

    // Rotate: one strobe per rising edge. The edge register keeps tracking the
    // key outside play so a key already held when play starts does not fire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rot_q       <= 1'b0;
            rotate_hold <= 1'b0;
        end else begin
            rot_q       <= key_rotate;
            rotate_hold <= in_play & key_rotate & ~rot_q;
        end
    end

    // Gravity tick. The active period is latched only when the counter wraps
    // (or sits at 0 outside play), so a level change never truncates or
    // stretches the interval already in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grav_cnt    <= 32'd0;
            grav_period <= BASE_PERIOD;
            force_down  <= 1'b0;
        end else if (!in_play) begin
            grav_cnt    <= 32'd0;
            grav_period <= next_period;
            force_down  <= 1'b0;
        end else if (grav_cnt >= grav_period - 32'd1) begin
            grav_cnt    <= 32'd0;
            grav_period <= next_period;
            force_down  <= 1'b1;
        end else begin
            grav_cnt    <= grav_cnt + 32'd1;
            force_down  <= 1'b0;
        end
    end

`ifdef GRAVITY_LEVEL_EN
    logic [3:0]  level_q;
    logic [31:0] level_thresh;

    // Gravity period for a level: linear speed-up, clamped at GRAV_MIN.
    function automatic logic [31:0] period_for(input logic [3:0] lvl);
        int p;
        p = GRAV_BASE - int'(lvl) * GRAV_STEP;
        if (p < GRAV_MIN) p = GRAV_MIN;
        if (p < 1) p = 1;
        return 32'(p);
    endfunction

    assign next_period = period_for(level_q);
    assign level       = level_q;

    // Level tracker: one step per cycle while score is at or above the next
    // threshold; a zero score means a new game and restarts the ladder.
    always_ff @(posedge clk) begin
        if (!rst) begin
            level_q      <= 4'd0;
            level_thresh <= 32'(LEVEL_PTS);
        end else if (score == 32'd0) begin
            level_q      <= 4'd0;
            level_thresh <= 32'(LEVEL_PTS);
        end else if ((score >= level_thresh) && (level_q != 4'd15)) begin
            level_q      <= level_q + 4'd1;
            level_thresh <= level_thresh + 32'(LEVEL_PTS);
        end
    end
`else
    logic unused_cfg;

    assign next_period = BASE_PERIOD;
    assign level       = 4'd0;
    assign unused_cfg  = ^{score, 32'(GRAV_STEP), 32'(GRAV_MIN), 32'(LEVEL_PTS)};
`endif

endmodule

// File: tb/tb_key_cmd_gen.sv
// Testbench for key_cmd_gen: directed scenarios plus a randomized run, all
// checked against a behavioural model of the key/gravity/level rules.
module tb_key_cmd_gen;

    localparam int         DD   = 16;
    localparam int         DR   = 4;
    localparam int         GB   = 64;
    localparam int         GS   = 4;
    localparam int         GM   = 8;
    localparam int         LP   = 10;
    localparam logic [4:0] PLAY = 5'd1;
`ifdef GRAVITY_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_left = 1'b0;
    logic        key_right = 1'b0;
    logic        key_down = 1'b0;
    logic        key_rotate = 1'b0;
    logic [4:0]  state = 5'd0;
    logic [31:0] score = 32'd0;
    logic        left, right, down, rotate_hold, force_down;
    logic [3:0]  level;
    logic [8:0]  act_v;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: number of consecutive effective-press edges per key,
    // edges since the last gravity wrap, active period, level ladder.
    int         m_n_l, m_n_r, m_n_d;
    bit         m_rot_prev;
    int         m_gcnt, m_gper, m_level;
    longint     m_thresh;
    logic [8:0] exp_v = 9'd0;

    always #5 clk = ~clk;

    key_cmd_gen #(
        .DAS_DELAY(DD), .DAS_RATE(DR), .GRAV_BASE(GB), .GRAV_STEP(GS),
        .GRAV_MIN(GM), .LEVEL_PTS(LP), .PLAY_CODE(PLAY)
    ) dut (
        .clk(clk), .rst(rst),
        .key_left(key_left), .key_right(key_right), .key_down(key_down),
        .key_rotate(key_rotate), .state(state), .score(score),
        .left(left), .right(right), .down(down), .rotate_hold(rotate_hold),
        .force_down(force_down), .level(level)
    );

    assign act_v = {left, right, down, rotate_hold, force_down, level};

    function automatic int exp_period(input int l);
        int p;
        if (!LVL_EN) return GB;
        p = GB - l * GS;
        return (p < GM) ? GM : p;
    endfunction

    // n-th consecutive held edge of left/right produces a pulse?
    function automatic bit das_fires(input int n);
        return (n == 1) || ((n - 1) >= DD && ((n - 1 - DD) % DR) == 0);
    endfunction

    task automatic model_edge();
        bit play, eff_l, eff_r, p_l, p_r, p_d, p_rot, p_fd;
        if (!rst) begin
            m_n_l = 0; m_n_r = 0; m_n_d = 0; m_rot_prev = 1'b0;
            m_gcnt = 0; m_gper = GB; m_level = 0; m_thresh = LP;
            exp_v = 9'd0;
            return;
        end
        play  = (state == PLAY);
        eff_l = play && key_left && !key_right;
        eff_r = play && key_right && !key_left;
        m_n_l = eff_l ? m_n_l + 1 : 0;
        m_n_r = eff_r ? m_n_r + 1 : 0;
        p_l   = eff_l && das_fires(m_n_l);
        p_r   = eff_r && das_fires(m_n_r);
        m_n_d = (play && key_down) ? m_n_d + 1 : 0;
        p_d   = (m_n_d > 0) && (((m_n_d - 1) % DR) == 0);
        p_rot = play && key_rotate && !m_rot_prev;
        m_rot_prev = key_rotate;
        p_fd  = 1'b0;
        if (!play) begin
            m_gcnt = 0;
            m_gper = exp_period(m_level);
        end else begin
            m_gcnt++;
            if (m_gcnt >= m_gper) begin
                p_fd   = 1'b1;
                m_gcnt = 0;
                m_gper = exp_period(m_level);
            end
        end
        if (LVL_EN) begin
            if (score == 32'd0) begin
                m_level = 0; m_thresh = LP;
            end else if (longint'({32'd0, score}) >= m_thresh && m_level < 15) begin
                m_level++; m_thresh += LP;
            end
        end
        exp_v = {p_l, p_r, p_d, p_rot, p_fd, 4'(m_level)};
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; state = PLAY; key_left = 1'b1; key_down = 1'b1; key_rotate = 1'b1;
        score = 32'd500;
        step(); step();
        n_checks++;
        if (act_v !== 9'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 000", act_v);
        end
        rst = 1'b1; state = 5'd0; key_left = 1'b0; key_down = 1'b0; key_rotate = 1'b0;
        score = 32'd0;
        step();
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++; $display("FAIL post_reset_idle: got %h want %h", act_v, exp_v);
        end
    endtask

    task automatic test_das_left();
        int got[$];
        int want[$] = '{1, 17, 21, 25, 29, 33, 37};
        state = PLAY;
        key_left = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL das_left_cycle%0d: got %h want %h", k, act_v, exp_v);
            end
            if (left) got.push_back(k);
            if (k == 40) key_left = 1'b0;
        end
        n_checks++;
        if (got.size() != want.size()) begin
            n_fail++; $display("FAIL das_left_count: got %0d pulses want %0d", got.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                n_checks++;
                if (got[i] != want[i]) begin
                    n_fail++; $display("FAIL das_left_pulse%0d: at cycle %0d want %0d", i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_both_lr();
        int seen;
        state = PLAY; key_left = 1'b1; key_right = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (left || right) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL both_lr_quiet: got %0d pulses want 0", seen);
        end
        key_right = 1'b0;
        step();
        n_checks++;
        if ({left, right} !== 2'b10 || act_v !== exp_v) begin
            n_fail++; $display("FAIL both_lr_release: got lr=%b want lr=10", {left, right});
        end
        key_left = 1'b0;
        step();
    endtask

    task automatic test_gravity();
        int got[$];
        int want[$] = '{64, 128, 192};
        int t, gap;
        key_left = 1'b0; key_right = 1'b0; key_down = 1'b0; key_rotate = 1'b0;
        score = 32'd0; state = 5'd0;
        step();
        state = PLAY;
        for (int k = 1; k <= 200; k++) begin
            step();
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL grav_cycle%0d: got %h want %h", k, act_v, exp_v);
            end
            if (force_down) got.push_back(k);
        end
        n_checks++;
        if (got.size() != 3 || got[0] != want[0] || got[1] != want[1] || got[2] != want[2]) begin
            n_fail++; $display("FAIL grav_ticks: got %0d ticks (first %0d) want 64,128,192",
                               got.size(), (got.size() > 0) ? got[0] : -1);
        end
        score = 32'd25;
        step(); step();
        n_checks++;
        if (int'(level) != (LVL_EN ? 2 : 0)) begin
            n_fail++; $display("FAIL level_25: got %0d want %0d", level, LVL_EN ? 2 : 0);
        end
        t = 0;
        do begin step(); t++; end while (!force_down && t < 200);
        gap = 0;
        do begin step(); gap++; end while (!force_down && gap < 200);
        n_checks++;
        if (gap != (LVL_EN ? 56 : 64)) begin
            n_fail++; $display("FAIL period_lvl2: got %0d want %0d", gap, LVL_EN ? 56 : 64);
        end
    endtask

    task automatic test_level_sat();
        int t, gap;
        score = 32'd1000;
        for (int k = 0; k < 16; k++) begin
            step();
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL lvl_ramp%0d: got %h want %h", k, act_v, exp_v);
            end
        end
        n_checks++;
        if (int'(level) != (LVL_EN ? 15 : 0)) begin
            n_fail++; $display("FAIL level_sat: got %0d want %0d", level, LVL_EN ? 15 : 0);
        end
        t = 0;
        do begin step(); t++; end while (!force_down && t < 200);
        gap = 0;
        do begin step(); gap++; end while (!force_down && gap < 200);
        n_checks++;
        if (gap != (LVL_EN ? 8 : 64)) begin
            n_fail++; $display("FAIL period_clamp: got %0d want %0d", gap, LVL_EN ? 8 : 64);
        end
        score = 32'd0;
        step();
        n_checks++;
        if (level !== 4'd0) begin
            n_fail++; $display("FAIL level_zero_score: got %0d want 0", level);
        end
    endtask

    task automatic test_rotate_down();
        int rot_cnt, gap;
        bit dn_at_fd;
        state = 5'd0;
        step(); step();
        state = PLAY; key_rotate = 1'b1;
        rot_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (rotate_hold) rot_cnt++;
        end
        key_rotate = 1'b0;
        step();
        n_checks++;
        if (rot_cnt != 1) begin
            n_fail++; $display("FAIL rotate_once: got %0d pulses want 1", rot_cnt);
        end
        key_down = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL down_hold%0d: got %h want %h", k, act_v, exp_v);
            end
        end
        state = 5'd3;
        step();
        n_checks++;
        if (down !== 1'b0 || force_down !== 1'b0) begin
            n_fail++; $display("FAIL down_stop: got down=%b fd=%b want 0 0", down, force_down);
        end
        key_down = 1'b0;
        step();
        state = PLAY;
        gap = 0; dn_at_fd = 1'b0;
        do begin
            step(); gap++;
            if (gap == 3) key_down = 1'b1;
            if (force_down) dn_at_fd = down;
        end while (!force_down && gap < 200);
        n_checks++;
        if (gap != exp_period(0)) begin
            n_fail++; $display("FAIL grav_restart: got %0d want %0d", gap, exp_period(0));
        end
        n_checks++;
        if (dn_at_fd !== 1'b1) begin
            n_fail++; $display("FAIL down_with_fd: got down=%b want 1", dn_at_fd);
        end
        key_down = 1'b0;
        step();
    endtask

    task automatic test_reset_repeat();
        int got[$];
        state = PLAY; key_right = 1'b1;
        for (int k = 0; k < 25; k++) step();
        rst = 1'b0;
        step();
        n_checks++;
        if (act_v !== 9'd0) begin
            n_fail++; $display("FAIL rst_in_repeat: got %h want 000", act_v);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (right !== 1'b1 || act_v !== exp_v) begin
            n_fail++; $display("FAIL rst_fresh_press: got %h want %h", act_v, exp_v);
        end
        for (int k = 2; k <= 20; k++) begin
            step();
            if (right) got.push_back(k);
        end
        n_checks++;
        if (got.size() != 1 || got[0] != 17) begin
            n_fail++; $display("FAIL rst_second_pulse: got %0d pulses (first %0d) want one at 17",
                               got.size(), (got.size() > 0) ? got[0] : -1);
        end
        key_right = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(7) == 0) key_left   = ~key_left;
            if ($urandom_range(7) == 0) key_right  = ~key_right;
            if ($urandom_range(7) == 0) key_down   = ~key_down;
            if ($urandom_range(5) == 0) key_rotate = ~key_rotate;
            state = ($urandom_range(19) == 0) ? 5'($urandom_range(31)) : PLAY;
            case ($urandom_range(199))
                0:       score = 32'd0;
                1:       score = $urandom;
                2, 3, 4, 5, 6, 7, 8, 9: score = score + $urandom_range(15);
                default: score = score;
            endcase
            rst = ($urandom_range(799) == 0) ? 1'b0 : 1'b1;
            step();
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL random_cycle%0d: got %h want %h", k, act_v, exp_v);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_das_left();
        test_both_lr();
        test_gravity();
        test_level_sat();
        test_rotate_down();
        test_reset_repeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
